// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard controller for the pipelined CPU.
// Tracks in-flight register writers in a destination pipeline that mirrors
// EX..WB (+ extra bypass latches), resolves the ID instruction's sources
// against the youngest producer, stalls ID on unready operands and registers
// the forward selects EX uses on the following cycle.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_id_valid              ID holds a real instruction
//   i_id_rs / i_id_rt       ID source registers
//   i_id_uses_rs / _rt      source is actually read
//   i_id_dest               ID destination register
//   i_id_reg_write          ID instruction writes i_id_dest
//   i_id_is_load            ID instruction is a load
//   i_flush                 squash ID and the stage-1 (EX) entry
//   o_stall                 combinational: hold PC/IF-ID, bubble into EX
//   o_fwd_sel_a / _b        registered operand sources for EX (0 = regfile)
//   o_stall_count           stall cycles since reset (wrapping)
module fwd_hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_READY  = 2,
  parameter int unsigned LOAD_READY = 3,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_is_load,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [SEL_W-1:0]  o_fwd_sel_a,
  output logic [SEL_W-1:0]  o_fwd_sel_b,
  output logic [CNT_W-1:0]  o_stall_count
);

  // Destination pipeline, stage 1 = EX .. stage DEPTH
  logic [DEPTH:1]    r_valid;
  logic [DEPTH:1]    r_wr;
  logic [DEPTH:1]    r_load;
  logic [REG_AW-1:0] r_dest [1:DEPTH];

  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic [CNT_W-1:0]  r_stall_count;

  logic [REG_AW-1:0] w_src [2];
  logic [1:0]        w_use;
  logic [1:0]        w_hazard;
  logic [SEL_W-1:0]  w_sel [2];
  logic              w_stall;
  logic              w_issue;

  assign w_src[0] = i_id_rs;
  assign w_src[1] = i_id_rt;
  assign w_use    = {i_id_uses_rt, i_id_uses_rs};

  // Per-source resolution. Scanning oldest to youngest lets the youngest
  // matching producer overwrite any older decision.
  always_comb begin
    w_hazard = '0;
    for (int s = 0; s < 2; s++) begin
      w_sel[s] = '0;
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_wr[k] && (r_dest[k] == w_src[s]) &&
            (w_src[s] != '0) && w_use[s]) begin
          // Producer will sit at stage k+1 when the consumer reaches EX
          if (k + 1 > DEPTH) begin
            w_sel[s]    = '0;
            w_hazard[s] = 1'b0;
          end else if (k + 1 >= (r_load[k] ? LOAD_READY : ALU_READY)) begin
            w_sel[s]    = SEL_W'(k + 1);
            w_hazard[s] = 1'b0;
          end else begin
            w_sel[s]    = '0;
            w_hazard[s] = 1'b1;
          end
        end
      end
    end
  end

  // Flush beats stall
  assign w_stall = i_id_valid && !i_flush && (|w_hazard);
  assign w_issue = i_id_valid && !w_stall && !i_flush;

  // Shift pipeline every cycle; flush kills the entry leaving stage 1
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_load  <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) r_dest[k] <= '0;
    end else begin
      r_valid[1] <= w_issue;
      r_wr[1]    <= i_id_reg_write;
      r_load[1]  <= i_id_is_load;
      r_dest[1]  <= i_id_dest;
      r_valid[2] <= r_valid[1] && !i_flush;
      r_wr[2]    <= r_wr[1];
      r_load[2]  <= r_load[1];
      r_dest[2]  <= r_dest[1];
      for (int unsigned k = 3; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_load[k]  <= r_load[k-1];
        r_dest[k]  <= r_dest[k-1];
      end
    end
  end

  // Forward selects follow the instruction into EX; bubbles carry 0
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else begin
      r_sel_a <= w_issue ? w_sel[0] : '0;
      r_sel_b <= w_issue ? w_sel[1] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_fwd_sel_a   = r_sel_a;
  assign o_fwd_sel_b   = r_sel_b;
  assign o_stall_count = r_stall_count;

endmodule
